// File: rtl/operand_entry_ctrl.sv
// Keypad operand entry / multiplier handshake controller.
// Optional build macro SIGNED_ENTRY_EN enables sign toggling with key 0xD.
module operand_entry_ctrl #(
  parameter int TIMEOUT_CYCLES = 32,
  parameter int MAX_DIGITS     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        mult_done,
  input  logic [15:0] mult_product,
  output logic [7:0]  op_a,
  output logic [7:0]  op_b,
  output logic        sign_a,
  output logic        sign_b,
  output logic        mult_start,
  output logic [15:0] disp_value,
  output logic [2:0]  state,
  output logic        key_reject
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ENTRYA = 3'd1;
  localparam logic [2:0] S_ENTRYB = 3'd2;
  localparam logic [2:0] S_START  = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_RESULT = 3'd5;
  localparam logic [2:0] S_ERROR  = 3'd6;
  localparam int CW = $clog2(MAX_DIGITS + 1);

  logic [2:0]    state_q, state_d;
  logic [7:0]    op_a_q, op_a_d, op_b_q, op_b_d, entry_q, entry_d, tmo_q, tmo_d;
  logic          sign_a_q, sign_a_d, sign_b_q, sign_b_d, rej_q, rej_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   result_q, result_d;

  logic        is_digit, digit_ok;
  logic [11:0] acc;

  // Accumulator wide enough for 255*10+9 so the range check can never wrap.
  assign acc      = ({4'd0, entry_q} * 12'd10) + {8'd0, key_code};
  assign is_digit = key_valid && (key_code <= 4'd9);
  assign digit_ok = (count_q < CW'(MAX_DIGITS)) && (acc <= 12'd255);

  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    entry_d  = entry_q;
    count_d  = count_q;
    result_d = result_q;
    tmo_d    = tmo_q;
    rej_d    = 1'b0;
    if (key_valid && key_code == 4'hC) begin
      state_d  = S_IDLE;
      op_a_d   = '0;
      op_b_d   = '0;
      sign_a_d = 1'b0;
      sign_b_d = 1'b0;
      entry_d  = '0;
      count_d  = '0;
      result_d = '0;
      tmo_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: if (is_digit) begin
          entry_d = {4'd0, key_code};
          count_d = CW'(1);
          state_d = S_ENTRYA;
        end
        S_ENTRYA, S_ENTRYB: if (is_digit) begin
          if (digit_ok) begin
            entry_d = acc[7:0];
            count_d = count_q + 1'b1;
          end else begin
            rej_d = 1'b1;
          end
        end else if (key_valid) begin
          if (key_code == 4'hB) begin
            entry_d = '0;
            count_d = '0;
          end else if (key_code == 4'hA && state_q == S_ENTRYA && count_q != '0) begin
            op_a_d  = entry_q;
            entry_d = '0;
            count_d = '0;
            state_d = S_ENTRYB;
          end else if (key_code == 4'hE && state_q == S_ENTRYB && count_q != '0) begin
            op_b_d  = entry_q;
            state_d = S_START;
          end
`ifdef SIGNED_ENTRY_EN
          else if (key_code == 4'hD) begin
            if (state_q == S_ENTRYA) sign_a_d = ~sign_a_q;
            else                     sign_b_d = ~sign_b_q;
          end
`endif
        end
        S_START: begin
          tmo_d   = '0;
          state_d = S_WAIT;
        end
        // Completion takes priority over a timeout landing in the same cycle.
        S_WAIT: if (mult_done) begin
          result_d = mult_product;
          state_d  = S_RESULT;
        end else if (tmo_q == 8'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_ERROR;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
        S_RESULT: if (is_digit) begin
          op_a_d   = '0;
          op_b_d   = '0;
          sign_a_d = 1'b0;
          sign_b_d = 1'b0;
          entry_d  = {4'd0, key_code};
          count_d  = CW'(1);
          state_d  = S_ENTRYA;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_a_q   <= '0;
      op_b_q   <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      entry_q  <= '0;
      count_q  <= '0;
      result_q <= '0;
      tmo_q    <= '0;
      rej_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      entry_q  <= entry_d;
      count_q  <= count_d;
      result_q <= result_d;
      tmo_q    <= tmo_d;
      rej_q    <= rej_d;
    end
  end

  always_comb begin
    disp_value = '0;
    if (state_q == S_ENTRYA || state_q == S_ENTRYB) disp_value = {8'd0, entry_q};
    else if (state_q == S_RESULT)                   disp_value = result_q;
  end

  assign op_a       = op_a_q;
  assign op_b       = op_b_q;
  assign sign_a     = sign_a_q;
  assign sign_b     = sign_b_q;
  assign state      = state_q;
  assign mult_start = (state_q == S_START);
  assign key_reject = rej_q;
endmodule

// File: tb/tb_operand_entry_ctrl.sv
// Directed + random bench for operand_entry_ctrl against a behavioural model.
module tb_operand_entry_ctrl;
  localparam int TMO  = 32;
  localparam int MAXD = 3;
`ifdef SIGNED_ENTRY_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, key_valid, mult_done;
  logic [3:0]  key_code;
  logic [15:0] mult_product;
  logic [7:0]  op_a, op_b;
  logic        sign_a, sign_b, mult_start, key_reject;
  logic [15:0] disp_value;
  logic [2:0]  state;

  operand_entry_ctrl #(.TIMEOUT_CYCLES(TMO), .MAX_DIGITS(MAXD)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .mult_done(mult_done), .mult_product(mult_product),
    .op_a(op_a), .op_b(op_b), .sign_a(sign_a), .sign_b(sign_b),
    .mult_start(mult_start), .disp_value(disp_value), .state(state),
    .key_reject(key_reject)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0, n_start = 0;
  // model: 0 idle,1 A,2 B,3 start,4 wait,5 result,6 error
  int m_st, m_a, m_b, m_sa, m_sb, m_ent, m_cnt, m_res, m_waited, m_rej;

  task automatic chk(string tag, int obs, int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clr_all();
    m_st = 0; m_a = 0; m_b = 0; m_sa = 0; m_sb = 0;
    m_ent = 0; m_cnt = 0; m_res = 0; m_waited = 0;
  endtask

  task automatic model(bit r, bit kv, int kc, bit md, int mp);
    bit dig;
    dig   = kv && kc <= 9;
    m_rej = 0;
    if (r || (kv && kc == 12)) begin
      clr_all();
      return;
    end
    case (m_st)
      0: if (dig) begin m_ent = kc; m_cnt = 1; m_st = 1; end
      1, 2: if (dig) begin
        if (m_cnt < MAXD && m_ent * 10 + kc <= 255) begin
          m_ent = m_ent * 10 + kc; m_cnt++;
        end else m_rej = 1;
      end else if (kv) begin
        if (kc == 11) begin m_ent = 0; m_cnt = 0; end
        else if (kc == 10 && m_st == 1 && m_cnt > 0) begin
          m_a = m_ent; m_ent = 0; m_cnt = 0; m_st = 2;
        end else if (kc == 14 && m_st == 2 && m_cnt > 0) begin
          m_b = m_ent; m_st = 3;
        end else if (kc == 13 && SGN) begin
          if (m_st == 1) m_sa = 1 - m_sa; else m_sb = 1 - m_sb;
        end
      end
      3: begin m_st = 4; m_waited = 0; end
      4: if (md) begin m_res = mp; m_st = 5; end
         else begin m_waited++; if (m_waited == TMO) m_st = 6; end
      5: if (dig) begin
        m_a = 0; m_b = 0; m_sa = 0; m_sb = 0; m_ent = kc; m_cnt = 1; m_st = 1;
      end
      default: ;
    endcase
  endtask

  task automatic cyc(bit r, bit kv, logic [3:0] kc, bit md, logic [15:0] mp);
    int exp_disp;
    rst = r; key_valid = kv; key_code = kc; mult_done = md; mult_product = mp;
    @(posedge clk);
    model(r, kv, int'(kc), md, int'(mp));
    #1;
    exp_disp = (m_st == 1 || m_st == 2) ? m_ent : (m_st == 5 ? m_res : 0);
    chk("state", state, m_st);
    chk("op_a", op_a, m_a);
    chk("op_b", op_b, m_b);
    chk("sign_a", sign_a, m_sa);
    chk("sign_b", sign_b, m_sb);
    chk("mult_start", mult_start, m_st == 3);
    chk("disp_value", disp_value, exp_disp);
    chk("key_reject", key_reject, m_rej);
    if (mult_start) n_start++;
    key_valid = 1'b0; mult_done = 1'b0; rst = 1'b0;
  endtask

  task automatic key(logic [3:0] k); cyc(0, 1, k, 0, 16'd0); endtask
  task automatic idle(int n); for (int i = 0; i < n; i++) cyc(0, 0, 4'd0, 0, 16'd0); endtask
  task automatic keys(input logic [3:0] ks[$]); foreach (ks[i]) key(ks[i]); endtask

  initial begin
    rst = 1'b1; key_valid = 1'b0; key_code = 4'd0; mult_done = 1'b0; mult_product = '0;
    clr_all(); m_rej = 0;
    cyc(1, 1, 4'd5, 1, 16'd9);
    chk("rst_state", state, 0); chk("rst_disp", disp_value, 0); chk("rst_opa", op_a, 0);

    // basic multiply: 12 * 3, done after 5 WAIT cycles
    n_start = 0;
    keys('{4'd1, 4'd2, 4'hA, 4'd3, 4'hE});
    idle(5);
    cyc(0, 0, 4'd0, 1, 16'd36);
    chk("mul_opa", op_a, 12); chk("mul_opb", op_b, 3); chk("mul_state", state, 5);
    chk("mul_disp", disp_value, 36); chk("mul_starts", n_start, 1);

    // digit rejection: value overflow and digit count
    keys('{4'hC, 4'd2, 4'd5, 4'd6});
    chk("rej_256", key_reject, 1); chk("ent_25", disp_value, 25);
    keys('{4'hB, 4'd9, 4'd9});
    chk("norej_99", key_reject, 0);
    key(4'd9);
    chk("rej_999", key_reject, 1); chk("ent_99", disp_value, 99);
    keys('{4'hB, 4'd1, 4'd0, 4'd0, 4'd1});
    chk("rej_cnt", key_reject, 1); chk("ent_100", disp_value, 100);

    // timeout -> ERROR, only C exits
    keys('{4'hC, 4'd1, 4'hA, 4'd2, 4'hE});
    idle(1 + TMO);
    chk("tmo_state", state, 6);
    key(4'd5);
    chk("err_hold", state, 6);
    key(4'hC);
    chk("err_exit", state, 0); chk("err_opa", op_a, 0); chk("err_disp", disp_value, 0);

    // done on the final WAIT cycle wins over timeout
    keys('{4'd1, 4'hA, 4'd2, 4'hE});
    idle(TMO);
    cyc(0, 0, 4'd0, 1, 16'd77);
    chk("edge_state", state, 5); chk("edge_disp", disp_value, 77);

    // C beats simultaneous mult_done
    keys('{4'd1, 4'hA, 4'd2, 4'hE});
    idle(3);
    cyc(0, 1, 4'hC, 1, 16'd99);
    chk("cdone_state", state, 0); chk("cdone_disp", disp_value, 0);

    // reset mid-WAIT, stray done afterwards ignored
    keys('{4'd1, 4'hA, 4'd2, 4'hE});
    idle(2);
    cyc(1, 0, 4'd0, 0, 16'd0);
    chk("rw_state", state, 0); chk("rw_opb", op_b, 0);
    cyc(0, 0, 4'd0, 1, 16'd55);
    chk("rw_done", state, 0);

    // sign keys
    keys('{4'd4, 4'hD, 4'hA, 4'd7, 4'hD, 4'hD, 4'hE});
    chk("sg_a", sign_a, SGN); chk("sg_b", sign_b, 0);
    chk("sg_opa", op_a, 4); chk("sg_opb", op_b, 7);

    // result -> new entry clears operands
    idle(3);
    cyc(0, 0, 4'd0, 1, 16'd28);
    key(4'd8);
    chk("res_new", state, 1); chk("res_opa", op_a, 0); chk("res_disp", disp_value, 8);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] kc;
      kc = 4'($urandom_range(0, 15));
      if (kc == 4'hC && $urandom_range(0, 3) != 0) kc = 4'hE;
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1, kc,
          $urandom_range(0, 5) == 0, 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
